pattern_scan_ctrl: RTL



---
 rtl/pattern_scan_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serializes handshaked words MSB-first into a runtime-programmed bit-pattern detector.
// Define PATTERN_OVERLAP_EN for overlapping detection; the default build detects non-overlapping matches.
module pattern_scan_ctrl #(
  parameter int W    = 8,
  parameter int PMAX = 8,
  parameter int CW   = 16,
  parameter int LW   = $clog2(PMAX + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [PMAX-1:0] cfg_pattern,
  input  logic [LW-1:0]   cfg_len,
  input  logic            start,
  input  logic [7:0]      cfg_words,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  output logic            in_ready,
  output logic            z,
  output logic [CW-1:0]   match_cnt,
  output logic            busy,
  output logic            done,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  localparam int SW = (W > 1) ? $clog2(W) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [PMAX-1:0] r_cfgPattern;
  logic [LW-1:0]   r_cfgLen;
  logic [PMAX-1:0] r_actPattern;
  logic [LW-1:0]   r_actLen;
  logic [PMAX-1:0] r_hist;
  logic [LW-1:0]   r_bitCnt;
  logic [7:0]      r_wordCnt;
  logic [W-1:0]    r_shReg;
  logic [SW-1:0]   r_shCnt;
  logic            r_z;
  logic [CW-1:0]   r_matchCnt;

  logic            w_start;
  logic            w_cfgLoad;
  logic            w_handshake;
  logic            w_shift;
  logic            w_lastBit;
  logic            w_bit;
  logic [PMAX-1:0] w_window;
  logic [LW-1:0]   w_bitCntNext;
  logic [PMAX:0]   w_maskWide;
  logic [PMAX-1:0] w_mask;
  logic [LW-1:0]   w_cfgLenClamped;
  logic            w_match;

  assign w_start         = (r_state == S_IDLE) && start;
  assign w_cfgLoad       = (r_state == S_IDLE) && cfg_we;
  assign w_handshake     = (r_state == S_LOAD) && in_valid;
  assign w_shift         = (r_state == S_SHIFT);
  assign w_lastBit       = w_shift && (r_shCnt == SW'(W - 1));
  assign w_bit           = r_shReg[W-1];
  assign w_window        = {r_hist[PMAX-2:0], w_bit};
  assign w_bitCntNext    = (r_bitCnt >= LW'(PMAX)) ? LW'(PMAX) : r_bitCnt + 1'b1;
  assign w_cfgLenClamped = (cfg_len > LW'(PMAX)) ? LW'(PMAX) : cfg_len;

  // Mask of the low len bits; the extra top bit lets len==PMAX produce all ones.
  assign w_maskWide = ((PMAX+1)'(1) << r_actLen) - (PMAX+1)'(1);
  assign w_mask     = w_maskWide[PMAX-1:0];

  assign w_match = w_shift && (r_actLen != '0) && (w_bitCntNext >= r_actLen) &&
                   (((w_window ^ r_actPattern) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = (cfg_words == 8'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_lastBit) begin
          w_next = (r_wordCnt > 8'd1) ? S_LOAD : S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The scan runs on a copy of the configuration taken at start, so a same-cycle
  // cfg_we only affects the following scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfgPattern <= '0;
      r_cfgLen     <= '0;
      r_actPattern <= '0;
      r_actLen     <= '0;
      r_hist       <= '0;
      r_bitCnt     <= '0;
      r_wordCnt    <= '0;
      r_shReg      <= '0;
      r_shCnt      <= '0;
      r_z          <= 1'b0;
      r_matchCnt   <= '0;
    end else begin
      r_z <= 1'b0;
      if (w_cfgLoad) begin
        r_cfgPattern <= cfg_pattern;
        r_cfgLen     <= w_cfgLenClamped;
      end
      if (w_start) begin
        r_actPattern <= r_cfgPattern;
        r_actLen     <= r_cfgLen;
        r_matchCnt   <= '0;
        r_hist       <= '0;
        r_bitCnt     <= '0;
        r_wordCnt    <= cfg_words;
      end
      if (w_handshake) begin
        r_shReg <= in_data;
        r_shCnt <= '0;
      end
      if (w_shift) begin
        r_shReg <= r_shReg << 1;
        r_shCnt <= r_shCnt + 1'b1;
        if (w_lastBit) begin
          r_wordCnt <= r_wordCnt - 1'b1;
        end
        if (w_match) begin
          r_z <= 1'b1;
          if (r_matchCnt != '1) begin
            r_matchCnt <= r_matchCnt + 1'b1;
          end
`ifdef PATTERN_OVERLAP_EN
          r_hist   <= w_window;
          r_bitCnt <= w_bitCntNext;
`else
          r_hist   <= '0;
          r_bitCnt <= '0;
`endif
        end else begin
          r_hist   <= w_window;
          r_bitCnt <= w_bitCntNext;
        end
      end
    end
  end

  assign z         = r_z;
  assign match_cnt = r_matchCnt;
  assign state     = r_state;

endmodule
